// File: rtl/phase_addr_gen.sv
// Phase accumulator that steps a 256-point table address once per sample tick.
// Define STEP_LATCH_EN to latch f_step only at period boundaries.
module phase_addr_gen #(
  parameter int unsigned DIV = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] f_step,
  output logic [7:0] addr,
  output logic       tick,
  output logic       wrap,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [15:0] LAST = 16'(DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  addr_q, addr_d;
  logic        tick_q, tick_d;
  logic        wrap_q, wrap_d;
  logic [7:0]  step_eff;
  logic [8:0]  sum;
  logic        tick_now;

  assign tick_now = (state_q != IDLE) && (presc_q == LAST);
  assign sum      = {1'b0, addr_q} + {1'b0, step_eff};

`ifdef STEP_LATCH_EN
  logic [7:0] step_q, step_d;
  logic       step_load;

  assign step_eff = step_q;

  // Reload on entry and on every period boundary only.
  always_comb begin
    step_load = 1'b0;
    if (state_q == IDLE && en)
      step_load = 1'b1;
    else if (tick_now && sum[8])
      step_load = 1'b1;
    step_d = step_load ? f_step : step_q;
  end

  always_ff @(posedge clk) begin
    if (rst) step_q <= 8'd0;
    else     step_q <= step_d;
  end
`else
  assign step_eff = f_step;
`endif

  always_comb begin
    state_d = state_q;
    presc_d = tick_now ? 16'd0 : presc_q + 16'd1;
    addr_d  = addr_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        presc_d = 16'd0;
        addr_d  = 8'd0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (tick_now) begin
          addr_d = sum[7:0];
          tick_d = 1'b1;
          wrap_d = sum[8];
        end
        if (!en) begin
          if (step_eff == 8'd0) begin
            // A zero step can never complete the period.
            state_d = IDLE;
            presc_d = 16'd0;
            addr_d  = 8'd0;
            tick_d  = 1'b0;
            wrap_d  = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (step_eff == 8'd0) begin
          state_d = IDLE;
          presc_d = 16'd0;
          addr_d  = 8'd0;
        end else if (tick_now && sum[8]) begin
          state_d = IDLE;
          presc_d = 16'd0;
          addr_d  = 8'd0;
          tick_d  = 1'b1;
          wrap_d  = 1'b1;
        end else begin
          if (tick_now) begin
            addr_d = sum[7:0];
            tick_d = 1'b1;
          end
          if (en) state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = 16'd0;
        addr_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= 16'd0;
      addr_q  <= 8'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      addr_q  <= addr_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign addr = addr_q;
  assign tick = tick_q;
  assign wrap = wrap_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_phase_addr_gen.sv
// Directed bench for phase_addr_gen with DIV = 4.
// Expected values are hand-derived from the sample-tick timing.
module tb_phase_addr_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] f_step;
  logic [7:0] addr;
  logic       tick;
  logic       wrap;
  logic       busy;

  int nchk = 0;
  int nerr = 0;

  phase_addr_gen #(.DIV(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .f_step (f_step),
    .addr   (addr),
    .tick   (tick),
    .wrap   (wrap),
    .busy   (busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic next_tick(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < 200);
    chk("tick_seen", tick, 1);
  endtask

  task automatic restart(input logic [7:0] f);
    rst = 1'b1;
    cyc();
    rst    = 1'b0;
    f_step = f;
    en     = 1'b1;
    cyc();
  endtask

  initial begin
    int n;
    int bad;
    int nt;
    rst    = 1'b1;
    en     = 1'b0;
    f_step = 8'd0;
    repeat (3) cyc();
    chk("rst_addr", addr, 0);
    chk("rst_tick", tick, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    cyc();
    chk("idle_busy", busy, 0);

    // Step 10: ticks every 4 clocks, wrap 250 -> 4.
    f_step = 8'd10;
    en     = 1'b1;
    cyc();
    chk("run_busy", busy, 1);
    bad = 0;
    for (int k = 1; k <= 25; k++) begin
      next_tick(n);
      if (n != 4 || addr != 8'(10 * k) || wrap || !busy) bad++;
    end
    chk("s10_seq_bad", bad, 0);
    next_tick(n);
    chk("s10_gap", n, 4);
    chk("s10_wrap_addr", addr, 4);
    chk("s10_wrap", wrap, 1);
    cyc();
    chk("s10_tick_pulse", tick, 0);
    chk("s10_wrap_pulse", wrap, 0);
    chk("s10_hold", addr, 4);

    // Step 1: 256 ticks per period, 255 + 1 wraps to exactly 0.
    restart(8'd1);
    bad = 0;
    for (int k = 1; k <= 255; k++) begin
      next_tick(n);
      if (n != 4 || addr != 8'(k) || wrap) bad++;
    end
    chk("s1_seq_bad", bad, 0);
    next_tick(n);
    chk("s1_wrap_addr", addr, 0);
    chk("s1_wrap", wrap, 1);

    // Drain from 120 finishes the period then idles.
    restart(8'd10);
    repeat (12) next_tick(n);
    chk("dr_start", addr, 120);
    en  = 1'b0;
    bad = 0;
    for (int k = 13; k <= 25; k++) begin
      next_tick(n);
      if (n != 4 || addr != 8'(10 * k) || wrap || !busy) bad++;
    end
    chk("dr_seq_bad", bad, 0);
    next_tick(n);
    chk("dr_end_addr", addr, 0);
    chk("dr_end_wrap", wrap, 1);
    chk("dr_end_busy", busy, 0);
    nt = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (tick) nt++;
    end
    chk("dr_no_ticks", nt, 0);
    chk("dr_idle_addr", addr, 0);

    // Drain interrupted by en returning: no discontinuity.
    restart(8'd10);
    repeat (12) next_tick(n);
    en = 1'b0;
    next_tick(n);
    chk("rs_drain_addr", addr, 130);
    en = 1'b1;
    next_tick(n);
    chk("rs_gap", n, 4);
    chk("rs_addr", addr, 140);
    repeat (11) next_tick(n);
    chk("rs_250", addr, 250);
    next_tick(n);
    chk("rs_wrap_addr", addr, 4);
    chk("rs_wrap", wrap, 1);
    chk("rs_busy", busy, 1);

    // Mid-period step change 4 -> 2.
    restart(8'd4);
    repeat (25) next_tick(n);
    chk("sc_start", addr, 100);
    f_step = 8'd2;
    next_tick(n);
`ifdef STEP_LATCH_EN
    chk("sc_next", addr, 104);
`else
    chk("sc_next", addr, 102);
`endif

    // Reset mid-run at prescaler 2, addr 80.
    restart(8'd10);
    repeat (8) next_tick(n);
    chk("mr_start", addr, 80);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("mr_addr", addr, 0);
    chk("mr_tick", tick, 0);
    chk("mr_wrap", wrap, 0);
    chk("mr_busy", busy, 0);
    rst = 1'b0;
    next_tick(n);
    chk("mr_first_gap", n, 5);
    chk("mr_first_addr", addr, 10);
    // Reset on the clock that would tick suppresses it.
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    chk("rp_tick", tick, 0);
    chk("rp_addr", addr, 0);
    rst = 1'b0;

`ifndef STEP_LATCH_EN
    // Zero step keeps ticking without moving, then idles at once.
    restart(8'd10);
    repeat (3) next_tick(n);
    f_step = 8'd0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      next_tick(n);
      if (n != 4 || addr != 8'd30 || wrap) bad++;
    end
    chk("z_seq_bad", bad, 0);
    en = 1'b0;
    cyc();
    chk("z_busy", busy, 0);
    chk("z_addr", addr, 0);
    chk("z_tick", tick, 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
